// File: rtl/lib_call_driver.sv
// Caller-side driver for fixed-latency library calls: credit-gated issue,
// LAT-deep valid pipeline tracking in-flight calls, FWFT result FIFO.
module lib_call_driver #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LAT        = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_W-1:0]               s_data1,
    input  logic [DATA_W-1:0]               s_data2,
    output logic                            c_ivalid,
    output logic                            c_iready,
    output logic [DATA_W-1:0]               c_datain1,
    output logic [DATA_W-1:0]               c_datain2,
    input  logic                            c_ovalid,
    input  logic                            c_oready,
    input  logic [DATA_W-1:0]               c_dataout,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_W-1:0]               m_data,
    output logic [$clog2(FIFO_DEPTH):0]     inflight,
    output logic                            overflow_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [LAT-1:0]    vpipe;
    logic              ready_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     inflight_q;
    logic              credit_ok;
    logic              issue;
    logic              tap;
    logic              full;
    logic              push;
    logic              pop;
    logic              unused_c_ovalid;

    // Capture timing comes from vpipe alone; the callee's valid is only observed.
    assign unused_c_ovalid = c_ovalid;

    // Credits use registered state only, so m_ready never reaches s_ready.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_C;
    assign s_ready   = ready_q && credit_ok && c_oready;
    assign issue     = s_valid && s_ready;
    assign tap       = vpipe[LAT-1];
    assign full      = (fifo_count == DEPTH_C[CW-1:0]);
    assign push      = tap && !full;
    assign pop       = m_valid && m_ready;

    assign c_ivalid  = issue;
    assign c_iready  = ready_q;
    assign c_datain1 = s_data1;
    assign c_datain2 = s_data2;

    assign m_valid   = (fifo_count != '0);
    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    assign inflight  = inflight_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            vpipe   <= '0;
        end else begin
            ready_q  <= 1'b1;
            vpipe[0] <= issue;
            for (int unsigned i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= '0;
        end else begin
            case ({issue, tap})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (tap && full) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= c_dataout;
    end

endmodule
